fnn_seq_ctrl: RTL and testbench
===============================

FNN_SEQ_CTRL -- requirements
Module: fnn_seq_ctrl

Interface
Parameters:
REQ-001 NUM_LAYERS, 3, number of weighted layers sequenced per sample; legal range 1 or more.
REQ-002 NEURONS, 10, neurons per layer, which is also the ld_reg bits per layer.
REQ-003 NUM_SAMPLES, 750, samples per run; legal range 2 or more.
Ports:
REQ-004 clk  in  1  clock, all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  run request, sampled in IDLE and DONE only.
REQ-007 mem_valid  in  1  input-memory data valid for the current sample_addr.
REQ-008 eq  in  1  predicted class equals label, valid in CLASSIFY.
REQ-009 read_mem_inp  out  1  input-memory read strobe.
REQ-010 sel_layer  out  LSW=$clog2(NUM_LAYERS+1)  weight/bias bank select; value NUM_LAYERS is the output stage.
REQ-011 ld_reg  out  NUM_LAYERS*NEURONS  register load enables; slice k is bits [k*NEURONS +: NEURONS].
REQ-012 read_mem_label  out  1  label-memory read strobe.
REQ-013 sample_addr  out  AW=$clog2(NUM_SAMPLES)  current sample index.
REQ-014 correct_cnt  out  CW=$clog2(NUM_SAMPLES+1)  running count of correct classifications.
REQ-015 busy  out  1  high in FETCH, LAYER and CLASSIFY.
REQ-016 done  out  1  high in DONE only.

Function
REQ-017 The FSM SHALL have the states IDLE, FETCH, LAYER, CLASSIFY and DONE; it SHALL hold an internal layer index lidx of width LSW.
REQ-018 IDLE: all strobes SHALL be 0; when start=1, sample_addr, correct_cnt and lidx SHALL clear to 0 and the next state SHALL be FETCH.
REQ-019 FETCH: read_mem_inp=1 and sel_layer=0 SHALL be driven; while mem_valid=0 the FSM SHALL stay in FETCH with ld_reg=0 (stall, indefinitely).
REQ-020 FETCH with mem_valid=1: ld_reg slice 0 SHALL be all-ones; the next state SHALL be LAYER with lidx=1 if NUM_LAYERS>1, otherwise CLASSIFY.
REQ-021 LAYER: sel_layer=lidx and ld_reg slice lidx all-ones SHALL be driven; lidx SHALL increment; after lidx=NUM_LAYERS-1 the next state SHALL be CLASSIFY.
REQ-022 CLASSIFY: sel_layer=NUM_LAYERS, read_mem_label=1 and ld_reg=0 SHALL be driven; correct_cnt SHALL increase by eq on the same edge.
REQ-023 CLASSIFY when sample_addr<NUM_SAMPLES-1: sample_addr SHALL increment and the next state SHALL be FETCH.
REQ-024 CLASSIFY when sample_addr=NUM_SAMPLES-1: sample_addr SHALL hold (no wrap) and the next state SHALL be DONE.
REQ-025 DONE: done=1 SHALL be driven and correct_cnt SHALL hold; start=1 SHALL restart the run exactly as from IDLE (clear counters, go to FETCH); start=0 SHALL stay in DONE.
REQ-026 start SHALL be ignored while busy=1.
REQ-027 At most one ld_reg slice SHALL be non-zero in any cycle, and all outputs SHALL be decoded from registered state only (Moore), except ld_reg in FETCH, which depends on mem_valid.
REQ-028 Latency with mem_valid held high: NUM_LAYERS+1 cycles per sample and NUM_SAMPLES*(NUM_LAYERS+1) cycles from the start edge to done (750*4=3000 at the defaults).
REQ-029 correct_cnt SHALL never exceed NUM_SAMPLES, so no saturation logic is required.

Reset
REQ-030 rst=1 SHALL force, asynchronously at any state including mid-run: state IDLE, lidx 0, sample_addr 0, correct_cnt 0 and all strobes, busy and done 0.
REQ-031 After rst is released, the FSM SHALL do nothing until the next start.

Structure
REQ-032 The package fnn_pkg SHALL hold the state enum and the default constants (NUM_LAYERS, NEURONS, NUM_SAMPLES).
REQ-033 A single sub-module, fnn_ld_decoder, SHALL map (enable, lidx) to the one-hot-slice ld_reg vector; all other logic SHALL stay in fnn_seq_ctrl.

Verification
REQ-034 Defaults, mem_valid=1, eq=1 always, start pulse -> done after 3000 cycles, correct_cnt=750, sample_addr=749.
REQ-035 eq=1 only on even samples -> correct_cnt=375 at done.
REQ-036 mem_valid held low for 5 cycles in sample 0 -> FETCH held 5 extra cycles with ld_reg=0 and read_mem_inp=1; total 3005 cycles.
REQ-037 rst asserted during sample 100 in LAYER (lidx=2) -> outputs clear immediately, IDLE; a new start gives a full 3000-cycle run.
REQ-038 NUM_LAYERS=1, NUM_SAMPLES=4 -> sequence FETCH, CLASSIFY repeated 4 times, done at cycle 8, only ld_reg slice 0 ever asserted.
REQ-039 start held high throughout the run -> no restart while busy; restart occurs on the first DONE cycle with counters cleared.

Source files
------------

// File: rtl/fnn_seq_ctrl_pkg.sv
// fnn_pkg: shared FSM state encoding and default sizing for the FNN sequencer
package fnn_pkg;

   localparam int DEF_NUM_LAYERS  = 3;
   localparam int DEF_NEURONS     = 10;
   localparam int DEF_NUM_SAMPLES = 750;

   typedef enum logic [2:0] {IDLE, FETCH, LAYER, CLASSIFY, DONE} state_t;

endpackage

// File: rtl/fnn_seq_ctrl_if.sv
// fnn_seq_ctrl_if: run control, memory strobes and layer-load bus of the sequencer
interface fnn_seq_ctrl_if
   import fnn_pkg::*;
#(
   parameter int NUM_LAYERS  = DEF_NUM_LAYERS,
   parameter int NEURONS     = DEF_NEURONS,
   parameter int NUM_SAMPLES = DEF_NUM_SAMPLES
);

   localparam int LSW = $clog2(NUM_LAYERS + 1);
   localparam int AW  = $clog2(NUM_SAMPLES);
   localparam int CW  = $clog2(NUM_SAMPLES + 1);

   logic                          start;
   logic                          mem_valid;
   logic                          eq;
   logic                          read_mem_inp;
   logic [LSW-1:0]                sel_layer;
   logic [NUM_LAYERS*NEURONS-1:0] ld_reg;
   logic                          read_mem_label;
   logic [AW-1:0]                 sample_addr;
   logic [CW-1:0]                 correct_cnt;
   logic                          busy;
   logic                          done;

   modport master (
      output start, mem_valid, eq,
      input  read_mem_inp, sel_layer, ld_reg, read_mem_label,
             sample_addr, correct_cnt, busy, done
   );

   modport slave (
      input  start, mem_valid, eq,
      output read_mem_inp, sel_layer, ld_reg, read_mem_label,
             sample_addr, correct_cnt, busy, done
   );

endinterface

// File: rtl/fnn_seq_ctrl_ld_decoder.sv
// fnn_ld_decoder: expands (enable, layer index) into one all-ones slice of the load-enable vector
module fnn_ld_decoder #(
   parameter int NUM_LAYERS = 3,
   parameter int NEURONS    = 10,
   parameter int LSW        = 2
) (
   input  logic                          en,
   input  logic [LSW-1:0]                idx,
   output logic [NUM_LAYERS*NEURONS-1:0] ld_reg
);

   for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_slice
      assign ld_reg[k*NEURONS +: NEURONS] = {NEURONS{en && idx == LSW'(k)}};
   end

endmodule

// File: rtl/fnn_seq_ctrl.sv
// fnn_seq_ctrl: steps each sample through fetch, every weighted layer and classification
module fnn_seq_ctrl
   import fnn_pkg::*;
#(
   parameter int NUM_LAYERS  = DEF_NUM_LAYERS,
   parameter int NEURONS     = DEF_NEURONS,
   parameter int NUM_SAMPLES = DEF_NUM_SAMPLES
) (
   input logic           clk,
   input logic           rst,
   fnn_seq_ctrl_if.slave bus
);

   localparam int LSW = $clog2(NUM_LAYERS + 1);
   localparam int AW  = $clog2(NUM_SAMPLES);
   localparam int CW  = $clog2(NUM_SAMPLES + 1);

   state_t         state, state_n;
   logic [LSW-1:0] lidx, lidx_n;
   logic [AW-1:0]  addr, addr_n;
   logic [CW-1:0]  cnt, cnt_n;
   logic           ld_en;

   // state and counters, cleared asynchronously so a mid-run reset aborts at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         lidx  <= '0;
         addr  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         lidx  <= lidx_n;
         addr  <= addr_n;
         cnt   <= cnt_n;
      end
   end

   // next state and counter updates; start only matters when not busy
   always_comb begin
      state_n = state;
      lidx_n  = lidx;
      addr_n  = addr;
      cnt_n   = cnt;
      case (state)
         IDLE, DONE: begin
            if (bus.start) begin
               state_n = FETCH;
               lidx_n  = '0;
               addr_n  = '0;
               cnt_n   = '0;
            end
         end
         FETCH: begin
            if (bus.mem_valid) begin
               state_n = NUM_LAYERS > 1 ? LAYER : CLASSIFY;
               lidx_n  = NUM_LAYERS > 1 ? LSW'(1) : '0;
            end
         end
         LAYER: begin
            lidx_n  = lidx + 1'b1;
            state_n = lidx == LSW'(NUM_LAYERS - 1) ? CLASSIFY : LAYER;
         end
         CLASSIFY: begin
            cnt_n  = cnt + CW'(bus.eq);
            lidx_n = '0;
            if (addr == AW'(NUM_SAMPLES - 1)) begin
               state_n = DONE;
            end else begin
               addr_n  = addr + 1'b1;
               state_n = FETCH;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.read_mem_inp   = state == FETCH;
   assign bus.read_mem_label = state == CLASSIFY;
   assign bus.sel_layer      = state == LAYER ? lidx : state == CLASSIFY ? LSW'(NUM_LAYERS) : '0;
   assign bus.sample_addr    = addr;
   assign bus.correct_cnt    = cnt;
   assign bus.busy           = state inside {FETCH, LAYER, CLASSIFY};
   assign bus.done           = state == DONE;
   assign ld_en              = (state == FETCH && bus.mem_valid) || state == LAYER;

   fnn_ld_decoder #(
      .NUM_LAYERS (NUM_LAYERS),
      .NEURONS    (NEURONS),
      .LSW        (LSW)
   ) u_ld_decoder (
      .en     (ld_en),
      .idx    (lidx),
      .ld_reg (bus.ld_reg)
   );

endmodule

// File: tb/tb_fnn_seq_ctrl.sv
// tb_fnn_seq_ctrl: randomized scoreboard bench for the FNN sequencer
module tb_fnn_seq_ctrl;

   localparam int NL  = 3;
   localparam int N   = 10;
   localparam int NS  = 750;
   localparam int LSW = $clog2(NL + 1);
   localparam int AW  = $clog2(NS);
   localparam int CW  = $clog2(NS + 1);

   typedef struct {
      logic          rd_inp;
      logic          rd_lbl;
      logic [LSW-1:0] sel;
      logic [NL*N-1:0] ld;
      logic [AW-1:0]  addr;
      logic [CW-1:0]  cnt;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   ev_t  q[$];
   ev_t  me;
   bit   eq_tab[NS];
   int   stall_tab[NS];
   int   fetch_seen = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fnn_seq_ctrl_if #(.NUM_LAYERS(NL), .NEURONS(N), .NUM_SAMPLES(NS)) bus ();
   fnn_seq_ctrl_if #(.NUM_LAYERS(1), .NEURONS(N), .NUM_SAMPLES(4)) bus2 ();

   fnn_seq_ctrl #(.NUM_LAYERS(NL), .NEURONS(N), .NUM_SAMPLES(NS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   fnn_seq_ctrl #(.NUM_LAYERS(1), .NEURONS(N), .NUM_SAMPLES(4)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reactive input driver: stalls each sample's fetch per stall_tab, answers eq per eq_tab
   always @(negedge clk) begin
      if (bus.read_mem_inp) begin
         bus.mem_valid = fetch_seen >= stall_tab[bus.sample_addr];
         fetch_seen++;
      end else begin
         bus.mem_valid = 1'($urandom);
         fetch_seen = 0;
      end
      bus.eq = bus.read_mem_label ? eq_tab[bus.sample_addr] : 1'($urandom);
   end

   // monitor: every strobe cycle must match the next predicted event
   always @(negedge clk) begin
      #2;
      if (bus.read_mem_inp || bus.read_mem_label || bus.ld_reg != '0) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got addr %0d ld %0h, expected no activity at %0t",
                     bus.sample_addr, bus.ld_reg, $time);
         end else begin
            me = q.pop_front();
            chk("ev_read_mem_inp", bus.read_mem_inp, me.rd_inp);
            chk("ev_read_mem_label", bus.read_mem_label, me.rd_lbl);
            chk("ev_sel_layer", bus.sel_layer, me.sel);
            chk("ev_ld_reg", bus.ld_reg, me.ld);
            chk("ev_sample_addr", bus.sample_addr, me.addr);
            chk("ev_correct_cnt", bus.correct_cnt, me.cnt);
            chk("ev_busy", bus.busy, 1);
         end
      end
   end

   // reference model: per sample, stall cycles, one load per layer, then a classify cycle
   task automatic prep(input int eq_mode, input int stall_mode, output int cyc, output int cnt);
      ev_t e;
      logic [NL*N-1:0] ones;
      ones = '0;
      ones[N-1:0] = '1;
      for (int s = 0; s < NS; s++) begin
         eq_tab[s] = eq_mode == 0 ? 1'b1 : eq_mode == 1 ? (s % 2 == 0) : 1'($urandom_range(0, 1));
         stall_tab[s] = stall_mode == 1 ? (s == 0 ? 5 : 0) :
                        stall_mode == 2 ? ($urandom_range(0, 9) == 0 ? int'($urandom_range(1, 4)) : 0) : 0;
      end
      q.delete();
      cyc = 0;
      cnt = 0;
      for (int s = 0; s < NS; s++) begin
         e.addr = AW'(s);
         e.cnt  = CW'(cnt);
         for (int k = 0; k < stall_tab[s]; k++) begin
            e.rd_inp = 1'b1; e.rd_lbl = 1'b0; e.sel = '0; e.ld = '0;
            q.push_back(e);
            cyc++;
         end
         for (int l = 0; l < NL; l++) begin
            e.rd_inp = l == 0; e.rd_lbl = 1'b0; e.sel = LSW'(l); e.ld = ones << (l * N);
            q.push_back(e);
            cyc++;
         end
         e.rd_inp = 1'b0; e.rd_lbl = 1'b1; e.sel = LSW'(NL); e.ld = '0;
         q.push_back(e);
         cyc++;
         cnt += int'(eq_tab[s]);
      end
   endtask

   task automatic wait_done(output int n);
      n = 0;
      forever begin
         @(negedge clk);
         #3;
         if (bus.done) break;
         n++;
         if (n > 20000) break;
      end
   endtask

   task automatic end_checks(input string tag, input int n, input int cyc, input int cnt);
      chk({tag, "_cycles"}, n, cyc);
      chk({tag, "_done"}, bus.done, 1);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_correct_cnt"}, bus.correct_cnt, cnt);
      chk({tag, "_sample_addr"}, bus.sample_addr, NS - 1);
      chk({tag, "_queue_drained"}, q.size(), 0);
   endtask

   task automatic run(input string tag, input int eq_mode, input int stall_mode);
      int cyc, cnt, n;
      prep(eq_mode, stall_mode, cyc, cnt);
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      wait_done(n);
      end_checks(tag, n, cyc, cnt);
      repeat (3) @(negedge clk);
      #3;
      chk({tag, "_done_hold"}, bus.done, 1);
      chk({tag, "_cnt_hold"}, bus.correct_cnt, cnt);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_done"}, bus.done, 0);
      chk({tag, "_read_mem_inp"}, bus.read_mem_inp, 0);
      chk({tag, "_read_mem_label"}, bus.read_mem_label, 0);
      chk({tag, "_ld_reg"}, bus.ld_reg, 0);
      chk({tag, "_sel_layer"}, bus.sel_layer, 0);
      chk({tag, "_sample_addr"}, bus.sample_addr, 0);
      chk({tag, "_correct_cnt"}, bus.correct_cnt, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end

   initial begin
      int cyc, cnt, n, t;
      bus.start = 1'b0;
      bus2.start = 1'b0;
      bus2.mem_valid = 1'b1;
      bus2.eq = 1'b1;
      for (int s = 0; s < NS; s++) begin
         eq_tab[s] = 1'b0;
         stall_tab[s] = 0;
      end
      #12;
      chk_quiet("reset");
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #3;
      chk_quiet("idle_after_reset");

      // single-layer, four-sample instance: fetch/classify alternate, done after 8 cycles
      @(negedge clk);
      bus2.start = 1'b1;
      @(posedge clk);
      #1 bus2.start = 1'b0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         #3;
         chk("nl1_read_mem_inp", bus2.read_mem_inp, j % 2 == 0);
         chk("nl1_read_mem_label", bus2.read_mem_label, j % 2 == 1);
         chk("nl1_ld_reg", bus2.ld_reg, j % 2 == 0 ? 10'h3ff : 10'h000);
         chk("nl1_sel_layer", bus2.sel_layer, j % 2);
         chk("nl1_sample_addr", bus2.sample_addr, j / 2);
      end
      @(negedge clk);
      #3;
      chk("nl1_done", bus2.done, 1);
      chk("nl1_correct_cnt", bus2.correct_cnt, 4);
      chk("nl1_sample_addr_end", bus2.sample_addr, 3);

      run("all_correct", 0, 0);
      run("even_correct", 1, 0);
      run("stall5", 0, 1);
      run("random", 2, 2);

      // abort in sample 100 while loading layer 2
      prep(2, 2, cyc, cnt);
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      t = 0;
      forever begin
         @(negedge clk);
         #1;
         if (bus.sample_addr == 100 && bus.sel_layer == 2 && bus.ld_reg[2*N +: N] != '0) break;
         t++;
         if (t > 5000) break;
      end
      chk("abort_point_reached", t > 5000, 0);
      rst = 1'b1;
      #1;
      chk_quiet("async_reset");
      q.delete();
      repeat (3) @(negedge clk);
      #3;
      chk_quiet("reset_held");
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      #3;
      chk_quiet("no_action_after_reset");
      run("after_abort", 0, 0);

      // start held high: no restart while busy, restart on the first done cycle
      prep(2, 0, cyc, cnt);
      @(negedge clk);
      bus.start = 1'b1;
      wait_done(n);
      end_checks("hold_start_1", n, cyc, cnt);
      prep(2, 2, cyc, cnt);
      @(posedge clk);
      #1 bus.start = 1'b0;
      wait_done(n);
      end_checks("hold_start_2", n, cyc, cnt);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
